// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester valid/ready arbiter and single-access sequencer for the unified memory.
// Optional MEM_ARB_ALIGN_CHECK_EN rejects misaligned half/word requests with rsp_err instead of accessing memory.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int PRIO_FIXED = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [3:0]          req_be,
  input  logic [63:0]         req_wdata,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic                mem_enable,
  output logic                mem_write_enable,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [1:0]          mem_byte_enable,
  output logic [31:0]         mem_wdata,
  output logic                mem_wdata_oe,
  input  logic [31:0]         mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;
  state_t state;
  logic owner, last_grant, win, bad, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0] sel_be;
  logic [31:0] sel_wdata;
  always_comb begin
    win = req_valid == 2'b10 || (req_valid == 2'b11 && PRIO_FIXED == 0 && !last_grant);
    sel_we = win ? req_we[1] : req_we[0];
    sel_addr = win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    sel_be = win ? req_be[3:2] : req_be[1:0];
    sel_wdata = win ? req_wdata[63:32] : req_wdata[31:0];
    req_ready = (state == IDLE && |req_valid) ? {win, !win} : 2'b00;
  end
`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign bad = sel_be[1] ? |sel_addr[1:0] : sel_be[0] & sel_addr[0];
`else
  assign bad = 1'b0;
`endif
  // Memory outputs default to 0 every cycle so they are only non-zero during ACCESS.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      mem_enable <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_addr <= '0;
      mem_byte_enable <= 2'b00;
      mem_wdata <= '0;
      mem_wdata_oe <= 1'b0;
    end else begin
      mem_enable <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_addr <= '0;
      mem_byte_enable <= 2'b00;
      mem_wdata <= '0;
      mem_wdata_oe <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          owner <= win;
          last_grant <= win;
          rsp_rdata <= '0;
          rsp_err <= bad;
          state <= bad ? RESP : ACCESS;
          rsp_valid <= bad ? {win, !win} : 2'b00;
          mem_enable <= !bad;
          mem_write_enable <= !bad && sel_we;
          mem_addr <= bad ? '0 : sel_addr;
          mem_byte_enable <= bad ? 2'b00 : sel_be;
          mem_wdata <= bad ? '0 : sel_wdata;
          mem_wdata_oe <= !bad && sel_we;
        end
        ACCESS: begin
          state <= mem_write_enable ? RESP : CAPTURE;
          rsp_valid <= mem_write_enable ? {owner, !owner} : 2'b00;
        end
        CAPTURE: begin
          rsp_rdata <= mem_rdata;
          rsp_valid <= {owner, !owner};
          state <= RESP;
        end
        RESP: if (rsp_ready[owner]) begin
          rsp_valid <= 2'b00;
          rsp_err <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a byte-addressed memory model with registered reads.
module tb_mem_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, preload = 1'b1;
  logic [1:0] req_valid = '0, req_ready, req_we = '0, rsp_valid, rsp_ready = 2'b11, mem_byte_enable;
  logic [15:0] req_addr = '0;
  logic [3:0] req_be = '0;
  logic [63:0] req_wdata = '0;
  logic [31:0] rsp_rdata, mem_wdata, mem_rdata = '0;
  logic rsp_err, mem_enable, mem_write_enable, mem_wdata_oe;
  logic [7:0] mem_addr;
  logic [1:0] f_req_ready, f_rsp_valid, f_mem_be;
  logic [31:0] f_rsp_rdata, f_mem_wdata;
  logic f_rsp_err, f_mem_en, f_mem_we, f_mem_oe;
  logic [7:0] f_mem_addr;
  logic [7:0] mem [256];
  int vectors = 0, miscompares = 0;
  int g[$], gc[$], fg[$];
  logic [1:0] seen;
  always #5 clk = ~clk;
  mem_arbiter #(.ADDR_W(8), .PRIO_FIXED(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_enable(mem_enable),
    .mem_write_enable(mem_write_enable), .mem_addr(mem_addr), .mem_byte_enable(mem_byte_enable),
    .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata));
  mem_arbiter #(.ADDR_W(8), .PRIO_FIXED(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .req_valid(2'b11), .req_ready(f_req_ready), .req_we(2'b11),
    .req_addr(16'h0804), .req_be(4'b1010), .req_wdata(64'h0), .rsp_valid(f_rsp_valid),
    .rsp_ready(2'b11), .rsp_rdata(f_rsp_rdata), .rsp_err(f_rsp_err), .mem_enable(f_mem_en),
    .mem_write_enable(f_mem_we), .mem_addr(f_mem_addr), .mem_byte_enable(f_mem_be),
    .mem_wdata(f_mem_wdata), .mem_wdata_oe(f_mem_oe), .mem_rdata(32'h0));
  // Little-endian memory; size code 00 = 1 byte, x1 = 2 bytes, 1x = 4 bytes; read data registered.
  always @(posedge clk)
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[16] <= 8'hEF; mem[17] <= 8'hBE; mem[18] <= 8'hAD; mem[19] <= 8'hDE;
    end else if (mem_enable) begin
      if (mem_write_enable) begin
        for (int k = 0; k < (mem_byte_enable[1] ? 4 : mem_byte_enable[0] ? 2 : 1); k++)
          mem[8'(mem_addr + k)] <= mem_wdata[8*k +: 8];
      end else begin
        mem_rdata <= {mem_byte_enable[1] ? {mem[8'(mem_addr + 3)], mem[8'(mem_addr + 2)]} : 16'h0,
                      |mem_byte_enable ? mem[8'(mem_addr + 1)] : 8'h0, mem[mem_addr]};
      end
    end
  always @(negedge clk)
    if (rst_n && |f_req_ready && fg.size() < 4) fg.push_back(int'(f_req_ready[1]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic rd0(input logic [7:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    req_valid = 2'b01; req_we = 2'b00; req_addr[7:0] = a; req_be[1:0] = 2'b10;
    #1 chk({tag, "_ready"}, 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    chk({tag, "_acc_en"}, 32'(mem_enable), 32'h1);
    chk({tag, "_acc_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_acc_oe"}, 32'(mem_wdata_oe), 32'h0);
    @(negedge clk);
    chk({tag, "_cap_en"}, 32'(mem_enable), 32'h0);
    chk({tag, "_cap_rv"}, 32'(rsp_valid), 32'h0);
    @(negedge clk);
    chk({tag, "_rv"}, 32'(rsp_valid), 32'h1);
    chk({tag, "_rdata"}, rsp_rdata, exp);
    chk({tag, "_err"}, 32'(rsp_err), 32'h0);
    @(negedge clk);
    chk({tag, "_done"}, 32'(rsp_valid), 32'h0);
  endtask
  task automatic wr1(input logic [7:0] a, input logic [31:0] d, input string tag);
    @(negedge clk);
    req_valid = 2'b10; req_we = 2'b10; req_addr[15:8] = a; req_be[3:2] = 2'b10; req_wdata[63:32] = d;
    #1 chk({tag, "_ready"}, 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 2'b00;
    chk({tag, "_acc_en"}, 32'(mem_enable), 32'h1);
    chk({tag, "_acc_we"}, 32'(mem_write_enable), 32'h1);
    chk({tag, "_acc_oe"}, 32'(mem_wdata_oe), 32'h1);
    chk({tag, "_acc_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_acc_wdata"}, mem_wdata, d);
    @(negedge clk);
    chk({tag, "_rv"}, 32'(rsp_valid), 32'h2);
    chk({tag, "_oe_off"}, 32'(mem_wdata_oe), 32'h0);
    chk({tag, "_en_off"}, 32'(mem_enable), 32'h0);
    chk({tag, "_rdata0"}, rsp_rdata, 32'h0);
    chk({tag, "_err"}, 32'(rsp_err), 32'h0);
    @(negedge clk);
    chk({tag, "_done"}, 32'(rsp_valid), 32'h0);
  endtask
  initial begin
    @(negedge clk);
    preload = 1'b0;
    chk("rst_rv", 32'(rsp_valid), 32'h0);
    chk("rst_en", 32'(mem_enable), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);
    rst_n = 1'b1;
    rd0(8'h10, 32'hDEADBEEF, "rd10");
    wr1(8'h20, 32'h12345678, "wr20");
    rd0(8'h20, 32'h12345678, "rd20");
    // Reset asserted in the middle of a write ACCESS cycle.
    @(negedge clk);
    req_valid = 2'b10; req_we = 2'b10; req_addr[15:8] = 8'h30; req_be[3:2] = 2'b10; req_wdata[63:32] = 32'h55AA55AA;
    #1 chk("mrst_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 2'b00;
    chk("mrst_acc_en", 32'(mem_enable), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("mrst_en", 32'(mem_enable), 32'h0);
    chk("mrst_we", 32'(mem_write_enable), 32'h0);
    chk("mrst_oe", 32'(mem_wdata_oe), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 2'b00;
    repeat (6) begin @(negedge clk); seen |= rsp_valid; end
    chk("mrst_no_rsp", 32'(seen), 32'h0);
    chk("mrst_no_write", {mem[51], mem[50], mem[49], mem[48]}, 32'h0);
    // Both requesters continuously valid: round-robin from a fresh reset.
    req_valid = 2'b11; req_we = 2'b11; req_addr = 16'h4440; req_be = 4'b1010;
    req_wdata = 64'h22222222_11111111;
    for (int c = 0; c < 40 && g.size() < 4; c++) begin
      #1 if (|req_ready) begin g.push_back(int'(req_ready[1])); gc.push_back(c); end
      @(negedge clk);
    end
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    chk("rr_count", 32'(g.size()), 32'h4);
    for (int i = 0; i < g.size(); i++) chk($sformatf("rr_grant%0d", i), 32'(g[i]), 32'(i % 2));
    if (gc.size() > 1) chk("rr_spacing", 32'(gc[1] - gc[0]), 32'h3);
    chk("fix_count", 32'(fg.size()), 32'h4);
    for (int i = 0; i < fg.size(); i++) chk($sformatf("fix_grant%0d", i), 32'(fg[i]), 32'h0);
    // Response backpressure with requester 1 waiting.
    @(negedge clk);
    rsp_ready = 2'b10; req_valid = 2'b11; req_we = 2'b10; req_addr = 16'h5010; req_be = 4'b1010;
    req_wdata = 64'hCAFEF00D_00000000;
    #1 chk("bp_ready0", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b10;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 chk($sformatf("bp_rv%0d", i), 32'(rsp_valid), 32'h1);
      chk($sformatf("bp_rdata%0d", i), rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("bp_ready%0d", i), 32'(req_ready), 32'h0);
    end
    @(negedge clk);
    rsp_ready = 2'b01;
    #1 chk("bp_hs_rv", 32'(rsp_valid), 32'h1);
    chk("bp_hs_noready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rsp_ready = 2'b11;
    #1 chk("bp_after_rv", 32'(rsp_valid), 32'h0);
    chk("bp_after_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 2'b00;
    chk("bp_wr_en", 32'(mem_enable), 32'h1);
    chk("bp_wr_addr", 32'(mem_addr), 32'h50);
    @(negedge clk);
    chk("bp_wr_rv", 32'(rsp_valid), 32'h2);
    @(negedge clk);
    chk("mem50", {mem[83], mem[82], mem[81], mem[80]}, 32'hCAFEF00D);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    @(negedge clk);
    req_valid = 2'b10; req_we = 2'b10; req_addr[15:8] = 8'h21; req_be[3:2] = 2'b10; req_wdata[63:32] = 32'hA5A5A5A5;
    #1 chk("mis_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 2'b00;
    chk("mis_en", 32'(mem_enable), 32'h0);
    chk("mis_rv", 32'(rsp_valid), 32'h2);
    chk("mis_err", 32'(rsp_err), 32'h1);
    chk("mis_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    chk("mis_done", 32'(rsp_valid), 32'h0);
    chk("mis_err_clr", 32'(rsp_err), 32'h0);
    rd0(8'h20, 32'h12345678, "mis_rd20");
`else
    wr1(8'h21, 32'hA5A5A5A5, "mis");
    rd0(8'h20, 32'hA5A5A578, "mis_rd20");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 256-byte unified memory (8-bit byte address, 32-bit data, byte_enable size code).
- Requester 0 is the instruction fetch unit; requester 1 is the load/store unit.
- Accepts one request at a time over a valid/ready handshake, drives a single memory access, captures registered read data and returns a response to the granted requester.
- Removes all contention on the memory's shared data bus by owning the write-data output enable.

Parameters:
- ADDR_W, 8, byte address width; must match the memory depth.
- PRIO_FIXED, 0, arbitration mode: 0 = round-robin, 1 = requester 0 always wins ties.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  2  bit i = requester i has a request
- req_ready  output  2  bit i = request i accepted this cycle; one-hot or zero
- req_we  input  2  bit i = request i is a write
- req_addr  input  2*ADDR_W  requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_be  input  4  2 bits per requester: 00 = byte, x1 = half, 1x = word
- req_wdata  input  64  32 bits per requester
- rsp_valid  output  2  one-hot; response for requester i
- rsp_ready  input  2  bit i = requester i consumes the response
- rsp_rdata  output  32  read data, shared by both requesters
- rsp_err  output  1  response error flag (see Optional Feature)
- mem_enable  output  1  memory enable
- mem_write_enable  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_byte_enable  output  2  memory size code
- mem_wdata  output  32  write data
- mem_wdata_oe  output  1  drive enable for the shared memory data bus
- mem_rdata  input  32  memory read data (registered inside the memory)

Behaviour:
- Reset (asynchronous, takes effect immediately on rst_n low):
  - state = IDLE.
  - All outputs 0.
  - Round-robin pointer last_grant = 1, so requester 0 wins the first tie.
  - Any in-flight access or pending response is dropped; no response is issued after reset.
- States: IDLE, ACCESS, CAPTURE, RESP.
- IDLE:
  - req_ready is combinational and only asserted in IDLE, to the winner.
  - Winner rule: the single valid requester if only one is valid. On a tie, with PRIO_FIXED = 1 requester 0 wins; with PRIO_FIXED = 0 the requester opposite last_grant wins.
  - On handshake: latch owner, we, addr, be and wdata into internal registers; update last_grant = owner; go to ACCESS.
- ACCESS (exactly one cycle):
  - Registered memory outputs: mem_enable = 1, mem_write_enable = latched we, and mem_addr, mem_byte_enable, mem_wdata from the latched request.
  - mem_wdata_oe = latched we.
  - Next state: CAPTURE if read, RESP if write.
- CAPTURE (read only, one cycle):
  - mem_enable = 0 and mem_wdata_oe = 0.
  - rsp_rdata <= mem_rdata at the end of the cycle.
  - Next state: RESP.
- RESP:
  - rsp_valid[owner] = 1.
  - rsp_rdata holds the captured read data; it is 0 for writes.
  - Stays in RESP until rsp_ready[owner] = 1, then goes to IDLE.
  - rsp_ready on the non-owner bit is ignored.
  - A new request can be accepted in the cycle after the response handshake, not in the same cycle.
- Latency from the req_ready cycle to the first rsp_valid cycle: read = 3 cycles, write = 2 cycles.
- Throughput: at most one access per 3 cycles (write) or 4 cycles (read).
- Memory outputs return to 0 in every cycle other than ACCESS.
- Address wrap-around (addr + 1..3 crossing 255) is the memory's concern; the arbiter forwards the address unmodified.
- A requester must hold its request stable while req_valid is high and req_ready is low. Dropping req_valid before the grant is legal; the request is simply never taken.
- With PRIO_FIXED = 0 and both requesters continuously valid, grants strictly alternate.

Optional Feature:
- Macro: MEM_ARB_ALIGN_CHECK_EN.
- With the macro defined:
  - In IDLE, a misaligned accepted request goes straight to RESP. Misaligned means half (be = 01) with addr[0] = 1, or word (be = 1x) with addr[1:0] != 0.
  - No ACCESS cycle is issued: mem_enable stays 0, and memory is unmodified for writes.
  - The response has rsp_err = 1 and rsp_rdata = 0.
  - rsp_err = 0 on aligned responses.
- Without the macro: rsp_err is tied to 0, and every request is forwarded unchecked.

Test Plan:
- Reset: rst_n low mid-ACCESS of a write -> mem_enable and mem_write_enable fall to 0 immediately, state is IDLE, and no rsp_valid follows reset release.
- Single read: requester 0 reads addr 0x10 (be = 10), memory holds 0xDEADBEEF -> mem_enable high exactly 1 cycle, rsp_valid = 01 exactly 3 cycles after req_ready, rsp_rdata = 0xDEADBEEF.
- Write then read: requester 1 writes 0x12345678 at 0x20 (be = 10) -> mem_wdata_oe = 1 only during ACCESS, rsp_valid = 10 after 2 cycles. A following read of 0x20 returns 0x12345678.
- Round-robin (PRIO_FIXED = 0): both requesters continuously valid for 4 grants -> grant order 0, 1, 0, 1. With PRIO_FIXED = 1 the order is 0, 0, 0, 0.
- Backpressure: hold rsp_ready = 0 for 5 cycles in RESP with requester 1 valid -> rsp_valid and rsp_rdata stable, req_ready stays 00, and the grant comes in the cycle after rsp_ready rises.
- Misaligned (with MEM_ARB_ALIGN_CHECK_EN): word write to 0x21 -> no mem_enable pulse, rsp_err = 1, rsp_rdata = 0, memory at 0x20..0x23 unchanged. Without the macro: access issued and rsp_err = 0.
